ifmap_row_packer: RTL and testbench

Front-end writer for the PE IFmap circular buffer. Accepts raw IFmap pixels from a valid/ready source stream and groups them into rows of a programmed length. Tags the first pixel of each row with a start bit and the last with an end bit, and writes the tagged words into the buffer under its ready/full handshake. Sits between the global feeder and the IFmap_buffer write port; it produces exactly the start/end encoding the PE's status decoder consumes.

---
 rtl/ifmap_row_packer.sv | 159 +++++++++++++++
 tb/tb_ifmap_row_packer.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/ifmap_row_packer.sv
// rtl/ifmap_row_packer.sv - groups source pixels into start/end tagged rows for the IFmap buffer
// A single holding register sits between the source stream and the buffer write port.
module ifmap_row_packer #(
  parameter int DATA_WIDTH    = 6,
  parameter int BUFFER_WIDTH  = 8,
  parameter int ROW_LEN_WIDTH = 5,
  parameter int ROW_CNT_WIDTH = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start,
  input  logic [ROW_LEN_WIDTH-1:0] row_len,
  input  logic [ROW_CNT_WIDTH-1:0] num_rows,
  input  logic                     src_valid,
  input  logic [DATA_WIDTH-1:0]    src_data,
  output logic                     src_ready,
  input  logic                     buf_ready,
  input  logic                     buf_full,
  output logic [BUFFER_WIDTH-1:0]  buf_din,
  output logic                     buf_wen,
  output logic                     busy,
  output logic                     done,
  output logic [ROW_CNT_WIDTH-1:0] rows_sent
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_STREAM,
    S_DRAIN,
    S_DONE
  } state_t;

  localparam logic [ROW_LEN_WIDTH-1:0] LEN_ONE  = ROW_LEN_WIDTH'(1);
  localparam logic [ROW_CNT_WIDTH-1:0] ROWS_ONE = ROW_CNT_WIDTH'(1);

  state_t                   state_q, state_d;
  logic [ROW_LEN_WIDTH-1:0] row_len_q, row_len_d;
  logic [ROW_CNT_WIDTH-1:0] num_rows_q, num_rows_d;
  logic [ROW_LEN_WIDTH-1:0] pix_cnt_q, pix_cnt_d;
  logic [ROW_CNT_WIDTH-1:0] row_cnt_q, row_cnt_d;
  logic [ROW_CNT_WIDTH-1:0] rows_sent_q, rows_sent_d;
  logic                     out_valid_q, out_valid_d;
  logic [BUFFER_WIDTH-1:0]  out_word_q, out_word_d;

  logic                     write_fire;
  logic                     accept;
  logic                     is_first_pix;
  logic                     is_last_pix;
  logic                     is_last_row;
  logic [BUFFER_WIDTH-1:0]  tagged_word;

  always_comb begin
    write_fire   = out_valid_q & buf_ready & ~buf_full;
    src_ready    = (state_q == S_STREAM) & (~out_valid_q | write_fire);
    accept       = src_valid & src_ready;
    is_first_pix = (pix_cnt_q == '0);
    is_last_pix  = (pix_cnt_q == (row_len_q - LEN_ONE));
    is_last_row  = (row_cnt_q == (num_rows_q - ROWS_ONE));

    tagged_word                   = '0;
    tagged_word[BUFFER_WIDTH-1]   = is_first_pix;
    tagged_word[BUFFER_WIDTH-2]   = is_last_pix;
    tagged_word[DATA_WIDTH-1:0]   = src_data;
  end

  always_comb begin
    state_d     = state_q;
    row_len_d   = row_len_q;
    num_rows_d  = num_rows_q;
    pix_cnt_d   = pix_cnt_q;
    row_cnt_d   = row_cnt_q;
    rows_sent_d = rows_sent_q;
    out_valid_d = out_valid_q;
    out_word_d  = out_word_q;

    // Holding register: a new accept overwrites the word being written this cycle.
    if (accept) begin
      out_word_d  = tagged_word;
      out_valid_d = 1'b1;
    end else if (write_fire) begin
      out_valid_d = 1'b0;
    end

    if (write_fire && out_word_q[BUFFER_WIDTH-2]) begin
      rows_sent_d = rows_sent_q + ROWS_ONE;
    end

    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          row_len_d   = row_len;
          num_rows_d  = num_rows;
          pix_cnt_d   = '0;
          row_cnt_d   = '0;
          rows_sent_d = '0;
          // An empty job has nothing held, so it passes straight through DRAIN.
          if ((row_len == '0) || (num_rows == '0)) begin
            state_d = S_DRAIN;
          end else begin
            state_d = S_STREAM;
          end
        end
      end
      S_STREAM: begin
        if (accept) begin
          if (is_last_pix) begin
            pix_cnt_d = '0;
            row_cnt_d = row_cnt_q + ROWS_ONE;
            if (is_last_row) begin
              state_d = S_DRAIN;
            end
          end else begin
            pix_cnt_d = pix_cnt_q + LEN_ONE;
          end
        end
      end
      S_DRAIN: begin
        if (!out_valid_d) begin
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      row_len_q   <= '0;
      num_rows_q  <= '0;
      pix_cnt_q   <= '0;
      row_cnt_q   <= '0;
      rows_sent_q <= '0;
      out_valid_q <= 1'b0;
      out_word_q  <= '0;
    end else begin
      state_q     <= state_d;
      row_len_q   <= row_len_d;
      num_rows_q  <= num_rows_d;
      pix_cnt_q   <= pix_cnt_d;
      row_cnt_q   <= row_cnt_d;
      rows_sent_q <= rows_sent_d;
      out_valid_q <= out_valid_d;
      out_word_q  <= out_word_d;
    end
  end

  assign buf_wen   = write_fire;
  assign buf_din   = out_valid_q ? out_word_q : '0;
  assign busy      = (state_q != S_IDLE);
  assign done      = (state_q == S_DONE);
  assign rows_sent = rows_sent_q;

endmodule

// File: tb/tb_ifmap_row_packer.sv
// tb/tb_ifmap_row_packer.sv - directed scoreboard bench for ifmap_row_packer
module tb_ifmap_row_packer;

  logic       clk;
  logic       rst;
  logic       start;
  logic [4:0] row_len;
  logic [7:0] num_rows;
  logic       src_valid;
  logic [5:0] src_data;
  logic       src_ready;
  logic       buf_ready;
  logic       buf_full;
  logic [7:0] buf_din;
  logic       buf_wen;
  logic       busy;
  logic       done;
  logic [7:0] rows_sent;

  ifmap_row_packer #(
    .DATA_WIDTH(6), .BUFFER_WIDTH(8), .ROW_LEN_WIDTH(5), .ROW_CNT_WIDTH(8)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .row_len(row_len), .num_rows(num_rows),
    .src_valid(src_valid), .src_data(src_data), .src_ready(src_ready),
    .buf_ready(buf_ready), .buf_full(buf_full), .buf_din(buf_din), .buf_wen(buf_wen),
    .busy(busy), .done(done), .rows_sent(rows_sent)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int writes, done_cnt, busy_cnt, done_cyc, last_acc_cyc, start_cyc, first_wr_cyc, last_wr_cyc;
  logic [5:0] src_q[$];
  logic [7:0] sb_q[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic new_job();
    writes = 0; done_cnt = 0; busy_cnt = 0; done_cyc = -1;
    last_acc_cyc = -1; first_wr_cyc = -1; last_wr_cyc = -1;
  endtask

  task automatic cycle(input bit stall_chk);
    logic       acc;
    logic [7:0] exp_word;
    @(negedge clk);
    if (stall_chk) begin
      chk("stall_wen", buf_wen, 1'b0);
      chk("stall_src_ready", src_ready, 1'b0);
      chk("stall_din_held", buf_din, (sb_q.size() > 0) ? sb_q[0] : 8'hxx);
    end
    if (buf_wen === 1'b1) begin
      writes++;
      if (first_wr_cyc < 0) first_wr_cyc = cyc;
      last_wr_cyc = cyc;
      if (sb_q.size() == 0) begin
        chk("unexpected_write", buf_din, 8'hxx);
      end else begin
        exp_word = sb_q.pop_front();
        chk("word", buf_din, exp_word);
      end
    end
    if (done === 1'b1) begin
      done_cnt++;
      done_cyc = cyc;
    end
    if (busy === 1'b1) busy_cnt++;
    acc = src_valid && (src_ready === 1'b1);
    if (acc) last_acc_cyc = cyc;
    @(posedge clk);
    #1;
    cyc++;
    if (acc && src_q.size() > 0) void'(src_q.pop_front());
    src_valid = (src_q.size() > 0);
    src_data  = src_valid ? src_q[0] : 6'h0;
  endtask

  task automatic do_start(input logic [4:0] len, input logic [7:0] rows);
    row_len = len; num_rows = rows; start = 1'b1; start_cyc = cyc;
    cycle(1'b0);
    start = 1'b0;
  endtask

  task automatic run_until_done(input int budget);
    int n = 0;
    while (done_cnt == 0 && n < budget) begin
      cycle(1'b0);
      n++;
    end
    cycle(1'b0);
    cycle(1'b0);
    chk("done_pulse_count", done_cnt, 1);
  endtask

  task automatic load_job1();
    for (int i = 1; i <= 6; i++) src_q.push_back(6'(i));
    sb_q.push_back(8'h81); sb_q.push_back(8'h02); sb_q.push_back(8'h43);
    sb_q.push_back(8'h84); sb_q.push_back(8'h05); sb_q.push_back(8'h46);
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; row_len = '0; num_rows = '0;
    src_valid = 1'b0; src_data = '0; buf_ready = 1'b1; buf_full = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    chk("reset_src_ready", src_ready, 1'b0);
    chk("reset_wen_din", {buf_wen, buf_din}, 9'h0);
    chk("reset_busy_done", {busy, done}, 2'b00);
    chk("reset_rows_sent", rows_sent, 8'h0);
    @(posedge clk);
    #1;

    // 3x2 job at full throughput
    new_job(); load_job1();
    do_start(5'd3, 8'd2);
    run_until_done(40);
    chk("t1_writes", writes, 6);
    chk("t1_back_to_back", last_wr_cyc - first_wr_cyc, 5);
    chk("t1_done_latency", done_cyc, last_acc_cyc + 2);
    chk("t1_rows_sent", rows_sent, 8'd2);
    chk("t1_idle", busy, 1'b0);
    chk("t1_sb_empty", sb_q.size(), 0);

    // single-pixel rows carry both tags
    new_job();
    src_q.push_back(6'h3F); src_q.push_back(6'h00); src_q.push_back(6'h15);
    sb_q.push_back(8'hFF); sb_q.push_back(8'hC0); sb_q.push_back(8'hD5);
    do_start(5'd1, 8'd3);
    run_until_done(40);
    chk("t2_writes", writes, 3);
    chk("t2_rows_sent", rows_sent, 8'd3);
    repeat (3) cycle(1'b0);
    chk("t2_rows_sent_held", rows_sent, 8'd3);

    // buffer full for 4 cycles mid-row
    new_job(); load_job1();
    do_start(5'd3, 8'd2);
    for (int n = 0; n < 20 && writes < 2; n++) cycle(1'b0);
    buf_full = 1'b1;
    repeat (4) cycle(1'b1);
    buf_full = 1'b0;
    run_until_done(40);
    chk("t3_writes", writes, 6);
    chk("t3_rows_sent", rows_sent, 8'd2);
    chk("t3_sb_empty", sb_q.size(), 0);

    // empty job
    new_job();
    do_start(5'd3, 8'd0);
    run_until_done(20);
    chk("t4_no_writes", writes, 0);
    chk("t4_busy_cycles", busy_cnt, 2);
    chk("t4_done_latency", done_cyc, start_cyc + 2);
    chk("t4_rows_sent", rows_sent, 8'd0);

    // reset mid-job, then a fresh 2x1 job
    new_job(); load_job1();
    do_start(5'd3, 8'd2);
    for (int n = 0; n < 20 && writes < 4; n++) cycle(1'b0);
    rst = 1'b1;
    src_q.delete();
    cycle(1'b0);
    sb_q.delete();
    rst = 1'b0;
    @(negedge clk);
    chk("t5_src_ready", src_ready, 1'b0);
    chk("t5_wen_din", {buf_wen, buf_din}, 9'h0);
    chk("t5_busy_done", {busy, done}, 2'b00);
    chk("t5_rows_sent", rows_sent, 8'h0);
    @(posedge clk);
    #1;
    new_job();
    src_q.push_back(6'h01); src_q.push_back(6'h02);
    sb_q.push_back(8'h81); sb_q.push_back(8'h42);
    do_start(5'd2, 8'd1);
    run_until_done(20);
    chk("t5_writes", writes, 2);
    chk("t5_rows_sent_new", rows_sent, 8'd1);

    // restart with a different row length during a job is ignored
    new_job(); load_job1();
    do_start(5'd3, 8'd2);
    cycle(1'b0);
    row_len = 5'd7; num_rows = 8'd1; start = 1'b1;
    cycle(1'b0);
    start = 1'b0;
    run_until_done(40);
    chk("t6_writes", writes, 6);
    chk("t6_rows_sent", rows_sent, 8'd2);
    chk("t6_sb_empty", sb_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
